// File: rtl/if_stage_pkg.sv
// Shared types for the fetch stage: opcode map, fixed instruction words and
// the fetch-state encoding.
package if_stage_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
      OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
      OP_LDI  = 4'h8, OP_LD   = 4'h9, OP_ST   = 4'hA, OP_JMP  = 4'hB,
      OP_BR   = 4'hC, OP_CALL = 4'hD, OP_RET  = 4'hE, OP_HLT  = 4'hF
   } opcode_e;

   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam logic [15:0] HLT_INSTR = 16'hF000;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: the stage requests an address, memory answers
// with a word and a ready strobe in the same cycle.
interface if_stage_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_rdy;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_rdy);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_rdy);
endinterface

// File: rtl/if_stage_next_pc.sv
// Next-PC selection: redirect, static backward-taken prediction, or increment.
// Prediction is compiled in only when BTFN_PREDICT_EN is defined.
module if_next_pc
   import if_stage_pkg::*;
(
   input  logic        i_redirect,
   input  logic [15:0] i_redirect_pc,
   input  logic [15:0] i_pc,
   input  logic        i_accept,
   input  logic [15:0] i_word,
   output logic [15:0] o_next_pc,
   output logic        o_pred_taken
);

   logic [15:0] w_seq_pc;
   logic [15:0] w_target;
   logic        w_taken;

   assign w_seq_pc = i_pc + 16'd1;

`ifdef BTFN_PREDICT_EN
   // Negative displacement on a conditional branch means a loop: guess taken.
   assign w_taken  = (opcode_e'(i_word[15:12]) == OP_BR) && i_word[7];
   assign w_target = w_seq_pc + sext8(i_word[7:0]);
`else
   logic w_unused;
   assign w_unused = ^i_word;
   assign w_taken  = 1'b0;
   assign w_target = w_seq_pc;
`endif

   always_comb begin
      o_next_pc = i_pc;
      if (i_redirect)
         o_next_pc = i_redirect_pc;
      else if (i_accept)
         o_next_pc = w_taken ? w_target : w_seq_pc;
   end

   assign o_pred_taken = i_accept & w_taken;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/FETCH/HALTED control and the IF/ID register.
// Optional BTFN_PREDICT_EN enables backward-taken branch prediction.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   if_stage_if.master  imem,
   output logic [15:0] instr,
   output logic [15:0] PC_inc,
   output logic        if_valid,
   output logic        pred_taken,
   output logic        halted
);

   fetch_state_e r_state, w_state_nxt;
   logic [15:0]  r_pc, r_instr, r_pc_inc;
   logic         r_if_valid, r_pred_taken;

   logic [15:0]  w_pc_nxt, w_instr_nxt, w_pc_inc_nxt;
   logic         w_if_valid_nxt, w_pred_nxt, w_pred_taken;
   logic         w_accept;

   assign w_accept = (r_state == ST_FETCH) & imem.imem_rdy & ~stall & ~redirect;

   if_next_pc u_next_pc (
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_pc          (r_pc),
      .i_accept      (w_accept),
      .i_word        (imem.imem_rdata),
      .o_next_pc     (w_pc_nxt),
      .o_pred_taken  (w_pred_taken)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_pc_inc     <= 16'h0000;
         r_if_valid   <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_instr      <= w_instr_nxt;
         r_pc_inc     <= w_pc_inc_nxt;
         r_if_valid   <= w_if_valid_nxt;
         r_pred_taken <= w_pred_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_instr_nxt    = r_instr;
      w_pc_inc_nxt   = r_pc_inc;
      w_if_valid_nxt = r_if_valid;
      w_pred_nxt     = r_pred_taken;
      if (redirect) begin
         w_state_nxt    = ST_FETCH;
         w_instr_nxt    = NOP_INSTR;
         w_if_valid_nxt = 1'b0;
         w_pred_nxt     = 1'b0;
      end else if (r_state == ST_BOOT) begin
         // BOOT is a fixed one-cycle warm-up, a stall does not extend it.
         w_state_nxt = ST_FETCH;
      end else if (!stall) begin
         case (r_state)
            ST_FETCH: begin
               if (imem.imem_rdy) begin
                  w_instr_nxt    = imem.imem_rdata;
                  w_pc_inc_nxt   = r_pc + 16'd1;
                  w_if_valid_nxt = 1'b1;
                  w_pred_nxt     = w_pred_taken;
                  if (imem.imem_rdata == HLT_INSTR)
                     w_state_nxt = ST_HALTED;
               end else begin
                  w_instr_nxt    = NOP_INSTR;
                  w_if_valid_nxt = 1'b0;
                  w_pred_nxt     = 1'b0;
               end
            end
            ST_HALTED: begin
               w_instr_nxt    = NOP_INSTR;
               w_if_valid_nxt = 1'b0;
               w_pred_nxt     = 1'b0;
            end
            default: w_state_nxt = ST_BOOT;
         endcase
      end
   end

   assign imem.imem_req  = (r_state == ST_FETCH);
   assign imem.imem_addr = r_pc;
   assign instr          = r_instr;
   assign PC_inc         = r_pc_inc;
   assign if_valid       = r_if_valid;
   assign pred_taken     = r_pred_taken;
   assign halted         = (r_state == ST_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, bubble, redirect,
// halt, prediction, PC wrap and asynchronous reset.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        rdy = 1'b0;
   logic [15:0] instr, PC_inc;
   logic        if_valid, pred_taken, halted;
   logic [15:0] mem [0:65535];
   int          checks = 0;
   int          fails  = 0;

   if_stage_if bus();

   assign bus.imem_rdata = mem[bus.imem_addr];
   assign bus.imem_rdy   = rdy;

   if_stage #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem(bus), .instr(instr), .PC_inc(PC_inc),
      .if_valid(if_valid), .pred_taken(pred_taken), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1;
      #3;
      checks++;
      if ({instr, PC_inc, if_valid, pred_taken, halted} !== {16'h0000, 16'h0000, 3'b000}) begin
         fails++; $display("FAIL reset_regs: got %h/%h/%b%b%b want 0000/0000/000", instr, PC_inc, if_valid, pred_taken, halted);
      end
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b0, 16'h0000}) begin
         fails++; $display("FAIL reset_bus: got req=%b addr=%h want 0/0000", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_seq_fetch();
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, if_valid} !== {1'b1, 16'h0000, 1'b0}) begin
         fails++; $display("FAIL boot_exit: got req=%b addr=%h v=%b want 1/0000/0", bus.imem_req, bus.imem_addr, if_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({instr, PC_inc, if_valid, bus.imem_addr} !== {mem[i], 16'(i + 1), 1'b1, 16'(i + 1)}) begin
            fails++; $display("FAIL seq_fetch%0d: got %h/%h/%b addr=%h want %h/%h/1 addr=%h", i, instr, PC_inc, if_valid, bus.imem_addr, mem[i], 16'(i + 1), 16'(i + 1));
         end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({instr, PC_inc, if_valid, bus.imem_addr} !== {16'h3456, 16'h0003, 1'b1, 16'h0003}) begin
            fails++; $display("FAIL stall_hold%0d: got %h/%h/%b addr=%h want 3456/0003/1 addr=0003", i, instr, PC_inc, if_valid, bus.imem_addr);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if ({instr, PC_inc, bus.imem_addr} !== {16'h4567, 16'h0004, 16'h0004}) begin
         fails++; $display("FAIL stall_resume: got %h/%h addr=%h want 4567/0004 addr=0004", instr, PC_inc, bus.imem_addr);
      end
   endtask

   task automatic test_bubble();
      rdy = 1'b0;
      tick();
      checks++;
      if ({instr, if_valid, bus.imem_req, bus.imem_addr} !== {16'h0000, 1'b0, 1'b1, 16'h0004}) begin
         fails++; $display("FAIL bubble: got %h/%b req=%b addr=%h want 0000/0 req=1 addr=0004", instr, if_valid, bus.imem_req, bus.imem_addr);
      end
      rdy = 1'b1;
      tick();
      checks++;
      if ({instr, PC_inc, if_valid} !== {16'h5678, 16'h0005, 1'b1}) begin
         fails++; $display("FAIL bubble_refetch: got %h/%h/%b want 5678/0005/1", instr, PC_inc, if_valid);
      end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
      tick();
      stall = 1'b0; redirect = 1'b0;
      checks++;
      if ({bus.imem_addr, if_valid, pred_taken, instr} !== {16'h0040, 1'b0, 1'b0, 16'h0000}) begin
         fails++; $display("FAIL redirect_over_stall: got addr=%h v=%b p=%b i=%h want 0040/0/0/0000", bus.imem_addr, if_valid, pred_taken, instr);
      end
      tick();
      checks++;
      if ({instr, PC_inc, if_valid} !== {16'h5000, 16'h0041, 1'b1}) begin
         fails++; $display("FAIL redirect_fetch: got %h/%h/%b want 5000/0041/1", instr, PC_inc, if_valid);
      end
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_pc = 16'h0005;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if ({instr, PC_inc, if_valid, halted, bus.imem_req, bus.imem_addr} !== {16'hF000, 16'h0006, 1'b1, 1'b1, 1'b0, 16'h0006}) begin
         fails++; $display("FAIL halt_accept: got %h/%h v=%b h=%b req=%b addr=%h want F000/0006 v=1 h=1 req=0 addr=0006", instr, PC_inc, if_valid, halted, bus.imem_req, bus.imem_addr);
      end
      tick();
      checks++;
      if ({instr, if_valid, halted, bus.imem_addr} !== {16'h0000, 1'b0, 1'b1, 16'h0006}) begin
         fails++; $display("FAIL halt_idle: got %h v=%b h=%b addr=%h want 0000 v=0 h=1 addr=0006", instr, if_valid, halted, bus.imem_addr);
      end
      redirect = 1'b1; redirect_pc = 16'h0010;
      tick();
      redirect = 1'b0;
      checks++;
      if ({halted, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 16'h0010}) begin
         fails++; $display("FAIL halt_exit: got h=%b req=%b addr=%h want h=0 req=1 addr=0010", halted, bus.imem_req, bus.imem_addr);
      end
      tick();
      checks++;
      if ({instr, PC_inc, if_valid} !== {16'h6111, 16'h0011, 1'b1}) begin
         fails++; $display("FAIL halt_resume: got %h/%h/%b want 6111/0011/1", instr, PC_inc, if_valid);
      end
   endtask

   task automatic test_predict();
      redirect = 1'b1; redirect_pc = 16'h0020;
      tick();
      redirect = 1'b0;
      tick();
`ifdef BTFN_PREDICT_EN
      checks++;
      if ({instr, PC_inc, bus.imem_addr, pred_taken} !== {16'hC0FE, 16'h0021, 16'h001F, 1'b1}) begin
         fails++; $display("FAIL predict_taken: got %h/%h addr=%h p=%b want C0FE/0021 addr=001F p=1", instr, PC_inc, bus.imem_addr, pred_taken);
      end
      tick();
      checks++;
      if ({instr, bus.imem_addr, pred_taken} !== {16'hC005, 16'h0020, 1'b0}) begin
         fails++; $display("FAIL predict_fwd: got %h addr=%h p=%b want C005 addr=0020 p=0", instr, bus.imem_addr, pred_taken);
      end
`else
      checks++;
      if ({instr, PC_inc, bus.imem_addr, pred_taken} !== {16'hC0FE, 16'h0021, 16'h0021, 1'b0}) begin
         fails++; $display("FAIL predict_off: got %h/%h addr=%h p=%b want C0FE/0021 addr=0021 p=0", instr, PC_inc, bus.imem_addr, pred_taken);
      end
`endif
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if ({instr, PC_inc, bus.imem_addr} !== {16'h2222, 16'h0000, 16'h0000}) begin
         fails++; $display("FAIL pc_wrap: got %h/%h addr=%h want 2222/0000 addr=0000", instr, PC_inc, bus.imem_addr);
      end
      tick();
      checks++;
      if ({instr, PC_inc} !== {16'h1234, 16'h0001}) begin
         fails++; $display("FAIL pc_wrap_next: got %h/%h want 1234/0001", instr, PC_inc);
      end
   endtask

   task automatic test_reset_midfetch();
      rdy = 1'b0; stall = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({instr, PC_inc, if_valid, pred_taken, halted, bus.imem_req, bus.imem_addr} !== {16'h0000, 16'h0000, 4'b0000, 16'h0000}) begin
         fails++; $display("FAIL async_reset: got %h/%h v=%b p=%b h=%b req=%b addr=%h want all zero", instr, PC_inc, if_valid, pred_taken, halted, bus.imem_req, bus.imem_addr);
      end
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; rdy = 1'b1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
         fails++; $display("FAIL reset_boot: got req=%b want 0", bus.imem_req);
      end
      tick();
      tick();
      checks++;
      if ({instr, PC_inc, if_valid} !== {16'h1234, 16'h0001, 1'b1}) begin
         fails++; $display("FAIL reset_refetch: got %h/%h/%b want 1234/0001/1", instr, PC_inc, if_valid);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
      mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'h2345;
      mem[16'h0002] = 16'h3456; mem[16'h0003] = 16'h4567;
      mem[16'h0004] = 16'h5678; mem[16'h0005] = 16'hF000;
      mem[16'h0010] = 16'h6111; mem[16'h001F] = 16'hC005;
      mem[16'h0020] = 16'hC0FE; mem[16'h0021] = 16'h1111;
      mem[16'h0040] = 16'h5000; mem[16'hFFFF] = 16'h2222;
      test_reset();
      test_seq_fetch();
      test_stall();
      test_bubble();
      test_redirect_stall();
      test_halt();
      test_predict();
      test_wrap();
      test_reset_midfetch();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard hold: PC and the IF/ID outputs freeze.
REQ-005 redirect  input  1  a resolved branch, CALL or RET from a later stage.
REQ-006 redirect_pc  input  16  target address when redirect=1.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  16  fetch address, equal to PC.
REQ-009 imem_rdata  input  16  instruction word, valid when imem_rdy=1.
REQ-010 imem_rdy  input  1  memory returns imem_rdata this cycle.
REQ-011 instr  output  16  registered IF/ID instruction.
REQ-012 PC_inc  output  16  registered IF/ID PC+1.
REQ-013 if_valid  output  1  instr/PC_inc carry a real instruction.
REQ-014 pred_taken  output  1  fetch predicted this branch taken.
REQ-015 halted  output  1  fetch stopped on HLT.

Function
REQ-016 The FSM SHALL have three states: BOOT, FETCH and HALTED.
REQ-017 BOOT lasts one cycle after reset release, holds imem_req=0, then goes to FETCH.
REQ-018 In FETCH: imem_req=1 and imem_addr=PC; in BOOT and HALTED: imem_req=0.
REQ-019 PC arithmetic is 16-bit modulo: PC_inc = PC+1, so 16'hFFFF wraps to 16'h0000.
REQ-020 Accept = FETCH & imem_rdy & !stall & !redirect: instr<=imem_rdata, PC_inc<=PC+1, if_valid<=1, PC<=next PC, all in one cycle.
REQ-021 FETCH & !imem_rdy & !stall & !redirect: NOP bubble (instr=16'h0000, if_valid=0); PC held; imem_req stays asserted.
REQ-022 stall & !redirect: PC, instr, PC_inc, if_valid and pred_taken are all held; any imem_rdata returned that cycle is discarded and refetched.
REQ-023 redirect has highest priority in every state: PC<=redirect_pc; IF/ID<=NOP; if_valid<=0; pred_taken<=0; state<=FETCH (this also leaves HALTED).
REQ-024 An accepted word 16'hF000 (HLT) is passed down with if_valid=1; state<=HALTED; halted=1; PC held at HLT address+1.
REQ-025 HALTED with no redirect: IF/ID<=NOP with if_valid=0, unless stall holds it.
REQ-026 Latency: request to IF/ID output is one cycle when imem_rdy is high in the request cycle.

Reset
REQ-027 rst low, asynchronous, sets: PC=RESET_PC, state=BOOT, instr=16'h0000, PC_inc=16'h0000, if_valid=0, pred_taken=0, halted=0.
REQ-028 Reset asserted mid-fetch or mid-stall abandons the outstanding request with no residual state.

Configuration
REQ-029 With BTFN_PREDICT_EN defined: an accepted word with opcode 4'hC and instr[7]=1 sets next PC = PC+1+sext(instr[7:0]) and registers pred_taken=1.
REQ-030 With BTFN_PREDICT_EN defined: all other accepted words set next PC=PC+1 and pred_taken=0.
REQ-031 Without BTFN_PREDICT_EN: next PC is always PC+1 and pred_taken is tied 0.

Structure
REQ-032 A shared package SHALL hold: opcode enum (4'h0-4'hF), NOP_INSTR=16'h0000, HLT_INSTR=16'hF000, and the fetch-state enum.
REQ-033 Next-PC selection (redirect / predict / increment) SHALL sit in one combinational sub-module, if_next_pc; the FSM and IF/ID registers stay in if_stage.

Verification
REQ-034 Reset release, imem_rdy=1, memory words A,B,C from 0 -> imem_addr 0,1,2 in consecutive cycles after BOOT; PC_inc 1,2,3; if_valid=1.
REQ-035 stall held 3 cycles mid-stream -> instr/PC_inc unchanged for 3 cycles; imem_addr constant; resumes with the next word.
REQ-036 redirect=1, redirect_pc=16'h0040, asserted together with stall -> next cycle imem_addr=16'h0040, if_valid=0; redirect wins.
REQ-037 Word 16'hF000 at 16'h0005 -> halted=1, imem_req=0; then redirect to 16'h0010 -> fetch resumes at 16'h0010, halted=0.
REQ-038 BTFN_PREDICT_EN defined, word 16'hC0FE at 16'h0020 -> next imem_addr=16'h001F, pred_taken=1; undefined -> 16'h0021, pred_taken=0.
REQ-039 PC=16'hFFFF fetched -> PC_inc=16'h0000 and the next imem_addr=16'h0000; rst pulsed while imem_rdy=0 -> outputs take reset values immediately.
